// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: issues sequential word reads over a req/ack handshake and
// buffers {inst, pc+4} in a first-word-fall-through queue; redirects flush and refetch.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  output logic                     o_mem_req,
  output logic [31:0]              o_mem_addr,
  input  logic                     i_mem_ack,
  input  logic [31:0]              i_mem_rdata,
  input  logic                     i_redirect,
  input  logic [31:0]              i_redirect_pc,
  input  logic                     i_take,
  output logic                     o_inst_valid,
  output logic [31:0]              o_inst,
  output logic [31:0]              o_pc_plus4,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  state_e            r_state, w_state_d;
  logic [31:0]       r_fetch_pc, w_fetch_pc_d;
  logic [31:0]       r_mem_addr, w_mem_addr_d;
  logic [CntW-1:0]   r_count, w_count_nxt;
  logic [PtrW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [31:0]       r_inst_mem [DEPTH];
  logic [31:0]       r_pc4_mem  [DEPTH];
  logic              w_push, w_pop;

  assign w_pop       = i_take && (r_count != '0) && !i_redirect;
  assign w_push      = (r_state == StReq) && i_mem_ack && !i_redirect;
  assign w_count_nxt = r_count + CntW'(w_push) - CntW'(w_pop);

  always_comb begin
    w_state_d    = r_state;
    w_fetch_pc_d = r_fetch_pc;
    w_mem_addr_d = r_mem_addr;
    if (i_redirect) begin
      w_fetch_pc_d = i_redirect_pc;
      // An unacked request must still drain before the target can be issued.
      if (r_state == StIdle || i_mem_ack) begin
        w_state_d    = StReq;
        w_mem_addr_d = i_redirect_pc;
      end else begin
        w_state_d = StDrop;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (r_count < Full) begin
            w_state_d    = StReq;
            w_mem_addr_d = r_fetch_pc;
          end
        end
        StReq: begin
          if (i_mem_ack) begin
            w_fetch_pc_d = r_fetch_pc + 32'd4;
            if (w_count_nxt < Full) begin
              w_mem_addr_d = r_fetch_pc + 32'd4;
            end else begin
              w_state_d = StIdle;
            end
          end
        end
        StDrop: begin
          if (i_mem_ack) begin
            w_state_d    = StReq;
            w_mem_addr_d = r_fetch_pc;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_fetch_pc <= RESET_PC;
      r_mem_addr <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_state    <= w_state_d;
      r_fetch_pc <= w_fetch_pc_d;
      r_mem_addr <= w_mem_addr_d;
      if (i_redirect) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        r_count <= w_count_nxt;
        if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) begin
      r_inst_mem[r_wr_ptr] <= i_mem_rdata;
      r_pc4_mem[r_wr_ptr]  <= r_fetch_pc + 32'd4;
    end
  end

  assign o_mem_req    = (r_state != StIdle);
  assign o_mem_addr   = r_mem_addr;
  assign o_count      = r_count;
  assign o_inst_valid = (r_count != '0);
  assign o_inst       = o_inst_valid ? r_inst_mem[r_rd_ptr] : 32'h0;
  assign o_pc_plus4   = o_inst_valid ? r_pc4_mem[r_rd_ptr] : 32'h0;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: a wait-state memory returning addr|A000_0000 and a
// program-order model of the instruction stream seen by decode.
module tb_fetch_prefetch_queue;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] Tag = 32'hA000_0000;

  logic        clk, rst;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
  logic        redirect, take, inst_valid;
  logic [31:0] redirect_pc, inst, pc_plus4;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;
  int lat   = 0;
  int wcnt  = 0;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clk(clk), .i_rst(rst), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .i_take(take), .o_inst_valid(inst_valid),
    .o_inst(inst), .o_pc_plus4(pc_plus4), .o_count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: acks after 'lat' wait cycles of a held request.
  always @(negedge clk) begin
    if (rst || !mem_req) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else begin
      if (mem_ack) wcnt = 0;
      if (wcnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr | Tag;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; take = 1'b0; redirect = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_inst [3];
    lat = 0; take = 1'b1; redirect = 1'b0; rst = 1'b1;
    @(negedge clk); @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || count !== 3'd0 || inst_valid !== 1'b0 || inst !== 32'h0 ||
        pc_plus4 !== 32'h0 || mem_addr !== RESET_PC) begin
      bad++;
      $display("FAIL reset_state: req=%b cnt=%0d v=%b inst=%h pc4=%h addr=%h want 0/0/0/0/0/%h",
               mem_req, count, inst_valid, inst, pc_plus4, mem_addr, RESET_PC);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== RESET_PC || inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL first_req: req=%b addr=%h v=%b want 1 %h 0", mem_req, mem_addr, inst_valid,
               RESET_PC);
    end
    exp_inst[0] = Tag; exp_inst[1] = Tag | 32'h4; exp_inst[2] = Tag | 32'h8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (inst_valid !== 1'b1 || inst !== exp_inst[i] || pc_plus4 !== 32'(4 * (i + 1))) begin
        bad++;
        $display("FAIL stream_%0d: v=%b inst=%h pc4=%h want 1 %h %h", i, inst_valid, inst,
                 pc_plus4, exp_inst[i], 32'(4 * (i + 1)));
      end
    end
    take = 1'b0;
  endtask

  task automatic test_fill();
    lat = 0;
    do_reset();
    for (int i = 0; i < 12 && count != 3'd4; i++) @(negedge clk);
    total++;
    if (count !== 3'd4 || mem_req !== 1'b0 || mem_addr !== 32'd12) begin
      bad++;
      $display("FAIL fill_full: cnt=%0d req=%b addr=%h want 4 0 c", count, mem_req, mem_addr);
    end
    take = 1'b1;
    @(negedge clk);
    take = 1'b0;
    total++;
    if (count !== 3'd3 || inst !== (Tag | 32'h4)) begin
      bad++;
      $display("FAIL fill_pop: cnt=%0d inst=%h want 3 %h", count, inst, Tag | 32'h4);
    end
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'd16) begin
      bad++;
      $display("FAIL fill_refetch: req=%b addr=%h want 1 10", mem_req, mem_addr);
    end
    @(negedge clk);
    total++;
    if (count !== 3'd4 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL fill_refull: cnt=%0d req=%b want 4 0", count, mem_req);
    end
  endtask

  task automatic test_wait_states();
    lat = 2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (mem_req !== 1'b1 || mem_addr !== RESET_PC || count !== 3'd0) begin
        bad++;
        $display("FAIL wait_hold_%0d: req=%b addr=%h cnt=%0d want 1 %h 0", i, mem_req, mem_addr,
                 count, RESET_PC);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (count !== 3'd1 || mem_addr !== 32'd4) begin
        bad++;
        $display("FAIL wait_push_%0d: cnt=%0d addr=%h want 1 4", i, count, mem_addr);
      end
    end
  endtask

  task automatic test_redirect();
    int n;
    lat = 2;
    do_reset();
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    total++;
    if (count !== 3'd0 || mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
      bad++;
      $display("FAIL redir_drop: cnt=%0d req=%b addr=%h want 0 1 %h", count, mem_req, mem_addr,
               RESET_PC);
    end
    @(negedge clk); @(negedge clk);
    total++;
    if (count !== 3'd0 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      bad++;
      $display("FAIL redir_target_req: cnt=%0d req=%b addr=%h want 0 1 100", count, mem_req,
               mem_addr);
    end
    n = 0;
    while (!inst_valid && n < 20) begin @(negedge clk); n++; end
    total++;
    if (inst_valid !== 1'b1 || inst !== (Tag | 32'h100) || pc_plus4 !== 32'h104) begin
      bad++;
      $display("FAIL redir_first: v=%b inst=%h pc4=%h want 1 %h 104", inst_valid, inst, pc_plus4,
               Tag | 32'h100);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    lat = 0;
    do_reset();
    for (int i = 0; i < 12 && count != 3'd2; i++) @(negedge clk);
    take = 1'b1;
    @(negedge clk);
    take = 1'b0;
    total++;
    if (count !== 3'd2 || inst !== (Tag | 32'h4)) begin
      bad++;
      $display("FAIL push_pop: cnt=%0d inst=%h want 2 %h", count, inst, Tag | 32'h4);
    end
    lat = 4;
    do_reset();
    take = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (count !== 3'd0 || inst_valid !== 1'b0) begin
        bad++;
        $display("FAIL empty_take_%0d: cnt=%0d v=%b want 0 0", i, count, inst_valid);
      end
    end
    take = 1'b0;
    n = 0;
    while (!inst_valid && n < 20) begin @(negedge clk); n++; end
    total++;
    if (count !== 3'd1 || inst !== Tag || pc_plus4 !== 32'h4) begin
      bad++;
      $display("FAIL empty_take_head: cnt=%0d inst=%h pc4=%h want 1 %h 4", count, inst, pc_plus4,
               Tag);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    lat = 3;
    do_reset();
    n = 0;
    while (!(count == 3'd3 && mem_req) && n < 60) begin @(negedge clk); n++; end
    total++;
    if (count !== 3'd3 || mem_req !== 1'b1) begin
      bad++;
      $display("FAIL midrst_setup: cnt=%0d req=%b want 3 1", count, mem_req);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (count !== 3'd0 || mem_req !== 1'b0 || inst !== 32'h0 || inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state: cnt=%0d req=%b inst=%h v=%b want 0 0 0 0", count, mem_req,
               inst, inst_valid);
    end
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
      bad++;
      $display("FAIL midrst_restart: req=%b addr=%h want 1 %h", mem_req, mem_addr, RESET_PC);
    end
  endtask

  // Decode must see consecutive PCs from the last redirect (or reset), each word matching
  // the memory image at its address.
  task automatic test_random();
    logic [31:0] exp_pc;
    int pops;
    exp_pc = RESET_PC;
    pops   = 0;
    lat    = 1;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      total++;
      if (inst_valid !== (count != 3'd0) || count > 3'(DEPTH)) begin
        bad++;
        $display("FAIL rnd_count_%0d: v=%b cnt=%0d", c, inst_valid, count);
      end
      total++;
      if (inst_valid) begin
        if (inst !== (exp_pc | Tag) || pc_plus4 !== exp_pc + 32'd4) begin
          bad++;
          $display("FAIL rnd_head_%0d: inst=%h pc4=%h want %h %h", c, inst, pc_plus4,
                   exp_pc | Tag, exp_pc + 32'd4);
        end
      end else if (inst !== 32'h0 || pc_plus4 !== 32'h0) begin
        bad++;
        $display("FAIL rnd_empty_%0d: inst=%h pc4=%h want 0 0", c, inst, pc_plus4);
      end
      lat      = $urandom_range(0, 3);
      redirect = ($urandom_range(0, 99) < 3);
      take     = ($urandom_range(0, 99) < 65);
      if (redirect) begin
        redirect_pc = $urandom & 32'h0FFF_FFFF;
        exp_pc      = redirect_pc;
      end else if (take && inst_valid) begin
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    redirect = 1'b0; take = 1'b0;
    total++;
    if (pops < 200) begin
      bad++;
      $display("FAIL rnd_progress: pops=%0d want >=200", pops);
    end
  endtask

  initial begin
    rst = 1'b1; take = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_fill();
    test_wait_states();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
Instruction-fetch front end that sits directly upstream of the pipeline's IF/ID register. It issues sequential word reads to a wait-state instruction memory over a req/ack handshake, and buffers the returned words with their PC+4 in a small FIFO. The head entry is presented to the decode stage. Branch/jump redirects from the pipeline flush the queue and restart fetch at the target.

Parameters:
DEPTH, 4, queue entries; power of two, at least 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
mem_req  out  1  read request to instruction memory
mem_addr  out  32  word address of the request; held stable while mem_req=1
mem_ack  in  1  memory returns mem_rdata this cycle; sampled only while mem_req=1
mem_rdata  in  32  instruction word; valid when mem_ack=1
redirect  in  1  flush and refetch; driven by the pipeline's PCSrc taken-branch/jump decision
redirect_pc  in  32  target address; valid with redirect
take  in  1  decode stage consumes the head entry this cycle (IF/ID write enable)
inst_valid  out  1  head entry present (count != 0)
inst  out  32  head instruction; 32'h0 (NOP) when empty
pc_plus4  out  32  head PC+4; 32'h0 when empty
count  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset, synchronous with rst=1 at the edge: state=IDLE, fetch_pc=RESET_PC, mem_addr=RESET_PC, mem_req=0, count=0, rd/wr pointers=0, inst_valid=0, inst=0, pc_plus4=0. Any outstanding memory request is abandoned; the memory shares rst.
- Queue: first-word-fall-through circular buffer of {inst, pc_plus4}. Head outputs are combinational from the buffer. Pointers wrap mod DEPTH.
- Pop: occurs when take=1, count>0 and redirect=0. take on an empty queue is ignored.
- Push: only from an accepted ack in state REQ. Push and pop in the same cycle leave count unchanged.
- FSM (Moore; mem_req=1 in REQ and DROP):
  - IDLE: if count<DEPTH, go to REQ with mem_addr<=fetch_pc.
  - REQ, mem_ack=1, no redirect: push {mem_rdata, fetch_pc+4}; fetch_pc<=fetch_pc+4. If the next-cycle count is below DEPTH, stay in REQ with mem_addr<=fetch_pc+4 (back-to-back fetch). Otherwise go to IDLE.
  - REQ, mem_ack=0: hold mem_addr and mem_req.
  - DROP: a squashed request is still outstanding. On mem_ack, discard mem_rdata and go to REQ with mem_addr<=fetch_pc. Without mem_ack, hold.
- Redirect has the highest priority in any state:
  - count<=0, pointers<=0, fetch_pc<=redirect_pc; take is ignored that cycle.
  - IDLE, REQ+ack, or DROP+ack: go to REQ with mem_addr<=redirect_pc; any same-cycle ack data is discarded.
  - REQ or DROP without ack: go to DROP; mem_addr keeps the old address until acked.
- At most one outstanding request. count cannot grow while a request is pending, so the reserved slot always exists at ack time.
- Latency:
  - First request is asserted 1 cycle after the reset-release edge.
  - With zero-wait memory (ack same cycle), inst_valid rises 2 cycles after reset release, then sustains 1 instruction/cycle.
  - After a redirect, the first target instruction is valid 2 cycles later if no request is outstanding; otherwise 2 cycles after the squashed request's ack.
- Arithmetic: PC increments are 32-bit, modulo 2^32; no alignment check (low two bits pass through).

Test Plan:
- Reset, zero-wait memory returning mem_rdata=mem_addr|32'hA000_0000, take=1: mem_req=1 with mem_addr=0 one cycle after release; inst_valid=1 two cycles after with inst=32'hA000_0000, pc_plus4=4; following cycles give inst ...0004/pc_plus4 8, ...0008/12, with no bubbles.
- Fill with take=0, zero-wait memory: count reaches 4 after 4 pushes; mem_req drops; mem_addr last=12. One take pulse: count 4->3, then a request for addr 16 and count back to 4.
- Memory acks 3 cycles after request: mem_addr stays constant and mem_req stays high for all 3 cycles; exactly one push per ack.
- Redirect with redirect_pc=32'h100 while REQ is outstanding (no ack): count=0 next cycle, state DROP with mem_addr unchanged. The ack's data is not enqueued. The next request has mem_addr=32'h100, and the first valid entry has pc_plus4=32'h104.
- count=2 with take=1 and an ack in the same cycle: count stays 2 and the head advances. take=1 at count=0 leaves count=0 and pointers unchanged.
- rst asserted mid-stream at count=3 with REQ outstanding: after the edge count=0, mem_req=0, inst=0. Fetch restarts at RESET_PC one cycle after release.
